dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 196 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for a RISC-V core: latches one load/store request, waits WAIT
// cycles, then commits the store or returns the extended load data with a one-cycle ready.
module dmem_responder #(
    parameter int unsigned WORDS = 256,
    parameter int unsigned WAIT  = 1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [9:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        err
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAITING, RESP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             latch_c, go_resp_c;

    logic             wr_q;
    logic [2:0]       f3_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;

    logic             wr_c;
    logic [2:0]       f3_c;
    logic [AW-1:0]    addr_c;
    logic [DW-1:0]    wdata_c;

    logic [IDX_W-1:0] idx_c;
    logic [DW-1:0]    word_c, load_c, store_word_c, lane_data_c;
    logic [7:0]       byte_c;
    logic [15:0]      half_c;
    logic [3:0]       mask_c;
    logic             mis_c, illegal_c, err_c, we_c;

    logic [DW-1:0]    mem [WORDS];

    // Request/FSM state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_c) begin
                wr_q    <= MemWrite;
                f3_q    <= funct3;
                addr_q  <= address;
                wdata_q <= write_data;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_c   = 1'b0;
        go_resp_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    latch_c = 1'b1;
                    if (WAIT == 0) begin
                        state_d   = RESP;
                        go_resp_c = 1'b1;
                    end else begin
                        state_d = WAITING;
                        cnt_d   = CNT_W'(WAIT - 1);
                    end
                end
            end
            WAITING: begin
                if (cnt_q == '0) begin
                    state_d   = RESP;
                    go_resp_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With WAIT=0 the commit edge is the accept edge, so the live inputs are used there
    always_comb begin
        if (state_q == IDLE) begin
            wr_c    = MemWrite;
            f3_c    = funct3;
            addr_c  = address;
            wdata_c = write_data;
        end else begin
            wr_c    = wr_q;
            f3_c    = f3_q;
            addr_c  = addr_q;
            wdata_c = wdata_q;
        end
    end

    assign idx_c  = IDX_W'(32'(addr_c[AW-1:2]) % WORDS);
    assign word_c = mem[idx_c];
    assign byte_c = 8'(word_c >> {addr_c[1:0], 3'b000});
    assign half_c = 16'(word_c >> {addr_c[1], 4'b0000});

    always_comb begin
        mis_c = 1'b0;
        case (f3_c[1:0])
            2'b01:   mis_c = addr_c[0];
            2'b10:   mis_c = |addr_c[1:0];
            default: mis_c = 1'b0;
        endcase
        illegal_c = (f3_c[1:0] == 2'b11)
                 || (wr_c && f3_c[2])
                 || (!wr_c && f3_c[2] && f3_c[1]);
        err_c = illegal_c || mis_c;
    end

    always_comb begin
        load_c = '0;
        case (f3_c)
            3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
            3'b001:  load_c = {{16{half_c[15]}}, half_c};
            3'b010:  load_c = word_c;
            3'b100:  load_c = {24'h0, byte_c};
            3'b101:  load_c = {16'h0, half_c};
            default: load_c = '0;
        endcase
    end

    // Byte-lane merge of the store into the current word
    always_comb begin
        mask_c      = 4'hf;
        lane_data_c = wdata_c;
        case (f3_c[1:0])
            2'b00: begin
                mask_c      = 4'b0001 << addr_c[1:0];
                lane_data_c = {4{wdata_c[7:0]}};
            end
            2'b01: begin
                mask_c      = addr_c[1] ? 4'b1100 : 4'b0011;
                lane_data_c = {2{wdata_c[15:0]}};
            end
            default: begin
                mask_c      = 4'hf;
                lane_data_c = wdata_c;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            store_word_c[i*8 +: 8] = mask_c[i] ? lane_data_c[i*8 +: 8] : word_c[i*8 +: 8];
        end
    end

    assign we_c = go_resp_c && wr_c && !err_c && RSTn;

    // Memory is intentionally not reset
    always_ff @(posedge CLK) begin
        if (we_c) begin
            mem[idx_c] <= store_word_c;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ready     <= 1'b0;
            err       <= 1'b0;
            read_data <= '0;
        end else begin
            ready <= go_resp_c;
            err   <= go_resp_c && err_c;
            if (go_resp_c) begin
                if (err_c) begin
                    read_data <= '0;
                end else if (!wr_c) begin
                    read_data <= load_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (WAIT=1, WAIT=3/WORDS=64, WAIT=0),
// each released from reset only while it is being exercised.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, rst_c;
    logic        mem_read, mem_write;
    logic [2:0]  f3;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        rdy  [3];
    logic [31:0] rdat [3];
    logic        er   [3];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WORDS(256), .WAIT(1)) u_w1 (
        .CLK(clk), .RSTn(rst_a), .MemRead(mem_read), .MemWrite(mem_write),
        .funct3(f3), .address(addr), .write_data(wdata),
        .read_data(rdat[0]), .ready(rdy[0]), .err(er[0])
    );

    dmem_responder #(.WORDS(64), .WAIT(3)) u_w3 (
        .CLK(clk), .RSTn(rst_b), .MemRead(mem_read), .MemWrite(mem_write),
        .funct3(f3), .address(addr), .write_data(wdata),
        .read_data(rdat[1]), .ready(rdy[1]), .err(er[1])
    );

    dmem_responder #(.WORDS(256), .WAIT(0)) u_w0 (
        .CLK(clk), .RSTn(rst_c), .MemRead(mem_read), .MemWrite(mem_write),
        .funct3(f3), .address(addr), .write_data(wdata),
        .read_data(rdat[2]), .ready(rdy[2]), .err(er[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    // Issue one request, scramble inputs after the sampling edge, check latency and pulse width
    task automatic do_req(input int d, input string tag, input logic rd, input logic wr,
                          input logic [2:0] fn, input logic [9:0] a, input logic [31:0] wd,
                          output logic [31:0] data, output logic e);
        int n = 0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; f3 = fn; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0; f3 = 3'b111; addr = 10'h3ff; wdata = 32'hffff_ffff;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (rdy[d]) break;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat_of(d)));
        data = rdat[d];
        e    = er[d];
        @(negedge clk);
        check({tag, "_pulse"}, 32'(rdy[d]), 32'h0);
    endtask

    task automatic ld(input int d, input string tag, input logic [2:0] fn, input logic [9:0] a,
                      input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] data;
        logic        e;
        do_req(d, tag, 1'b1, 1'b0, fn, a, 32'h0, data, e);
        check({tag, "_data"}, data, exp_d);
        check({tag, "_err"}, 32'(e), 32'(exp_e));
    endtask

    task automatic st(input int d, input string tag, input logic rd, input logic [2:0] fn,
                      input logic [9:0] a, input logic [31:0] wd, input logic exp_e);
        logic [31:0] data;
        logic        e;
        do_req(d, tag, rd, 1'b1, fn, a, wd, data, e);
        check({tag, "_err"}, 32'(e), 32'(exp_e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; f3 = 3'b000; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(rdy[0]), 32'h0);
        check("rst_err",   32'(er[0]),  32'h0);
        check("rst_rdata", rdat[0],     32'h0);
        rst_a = 1'b1;

        // WAIT=1 instance
        st(0, "sw_beef", 1'b0, 3'b010, 10'h010, 32'hdead_beef, 1'b0);
        ld(0, "lw_beef", 3'b010, 10'h010, 32'hdead_beef, 1'b0);
        st(0, "sw_zero", 1'b0, 3'b010, 10'h010, 32'h0, 1'b0);
        st(0, "sb_80",   1'b0, 3'b000, 10'h013, 32'h0000_0080, 1'b0);
        ld(0, "lb_13",   3'b000, 10'h013, 32'hffff_ff80, 1'b0);
        ld(0, "lbu_13",  3'b100, 10'h013, 32'h0000_0080, 1'b0);
        ld(0, "lw_10",   3'b010, 10'h010, 32'h8000_0000, 1'b0);
        ld(0, "lh_12",   3'b001, 10'h012, 32'hffff_8000, 1'b0);
        ld(0, "lhu_12",  3'b101, 10'h012, 32'h0000_8000, 1'b0);
        st(0, "sw_20",   1'b0, 3'b010, 10'h020, 32'hcafe_f00d, 1'b0);
        st(0, "sh_mis",  1'b0, 3'b001, 10'h021, 32'h0000_1234, 1'b1);
        st(0, "st_f3_4", 1'b0, 3'b100, 10'h020, 32'h0000_5555, 1'b1);
        ld(0, "lw_20",   3'b010, 10'h020, 32'hcafe_f00d, 1'b0);
        st(0, "rw_both", 1'b1, 3'b010, 10'h004, 32'h0000_0005, 1'b0);
        check("st_keeps_rdata", rdat[0], 32'hcafe_f00d);
        ld(0, "lw_04",   3'b010, 10'h004, 32'h0000_0005, 1'b0);
        ld(0, "ld_f3_3", 3'b011, 10'h020, 32'h0, 1'b1);
        ld(0, "lw_mis",  3'b010, 10'h022, 32'h0, 1'b1);
        rst_a = 1'b0;

        // WAIT=3, WORDS=64 instance: wrap-around and reset abort
        @(negedge clk);
        rst_b = 1'b1;
        st(1, "wrap_sw", 1'b0, 3'b010, 10'h108, 32'h1234_5678, 1'b0);
        ld(1, "wrap_lw", 3'b010, 10'h008, 32'h1234_5678, 1'b0);
        st(1, "sw_aaaa", 1'b0, 3'b010, 10'h008, 32'haaaa_5555, 1'b0);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b1; f3 = 3'b010; addr = 10'h008; wdata = 32'h1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        check("abort_rst_ready", 32'(rdy[1]), 32'h0);
        rst_b = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy[1]) cnt++;
        end
        check("abort_no_ready", 32'(cnt), 32'h0);
        ld(1, "abort_lw", 3'b010, 10'h008, 32'haaaa_5555, 1'b0);
        rst_b = 1'b0;

        // WAIT=0 instance: back-to-back loads, stores offered only during RESP
        @(negedge clk);
        rst_c = 1'b1;
        st(2, "w0_sw", 1'b0, 3'b010, 10'h030, 32'h0000_0011, 1'b0);
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; f3 = 3'b010; addr = 10'h030; wdata = 32'h77;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("b2b_rdy%0d", i), 32'(rdy[2]), 32'(i % 2 == 0));
            if (i % 2 == 0) begin
                check($sformatf("b2b_data%0d", i), rdat[2], 32'h0000_0011);
                mem_read = 1'b0; mem_write = 1'b1;
            end else begin
                mem_read = 1'b1; mem_write = 1'b0;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        repeat (2) @(negedge clk);
        ld(2, "b2b_after", 3'b010, 10'h030, 32'h0000_0011, 1'b0);
        rst_c = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
